prefix_xor_seq: RTL and testbench

Multi-cycle sequencer that computes the prefix XOR (running parity, `PO[i] = PI[0] ^ … ^ PI[i]`) of a wide operand using one shared `width`-bit PrefixXor instance. It accepts a `width*chunks`-bit operand over a valid/ready handshake and feeds it through the datapath one chunk per cycle, LSB chunk first. A single carry bit links consecutive chunks. It sits in front of wide Gray-to-binary and parity paths, where a full-width prefix tree is too large.

---
 rtl/prefix_xor_seq_if.sv | 33 +++
 rtl/prefix_xor_seq.sv | 168 ++++++++++++++++
 tb/tb_prefix_xor_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_xor_seq_if.sv
// Operand/result handshake bundle for prefix_xor_seq.
// W is the full operand width (width*chunks).
interface prefix_xor_seq_if #(
    parameter int W = 32
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_data_o;
    logic         busy_o;

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  busy_o
    );

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output busy_o
    );
endinterface

// File: rtl/prefix_xor_seq.sv
// Chunk-serial prefix XOR over a wide operand with one shared prefix tree.
// Define PREFIX_XOR_SEQ_OVERLAP_EN to accept a new operand during the output handshake.
module prefix_xor #(
    parameter int width = 8,
    parameter int speed = 0
) (
    input  logic [width-1:0] pi,
    output logic [width-1:0] po
);
    localparam int LV = (width > 1) ? $clog2(width) : 1;

    logic [width-1:0] t;
    logic [width-1:0] p;

    generate
        if (speed == 2) begin : g_sklansky
            always_comb begin
                t = pi;
                p = pi;
                for (int l = 0; l < LV; l++) begin
                    p = t;
                    for (int i = 0; i < width; i++) begin
                        if (((i >> l) & 1) == 1)
                            t[i] = t[i] ^ p[((i >> l) << l) - 1];
                    end
                end
                po = t;
            end
        end else if (speed == 1) begin : g_brent_kung
            always_comb begin
                t = pi;
                p = '0;
                for (int l = 0; l < LV; l++) begin
                    for (int i = 0; i < width; i++) begin
                        if (((i + 1) % (2 << l)) == 0)
                            t[i] = t[i] ^ t[i - (1 << l)];
                    end
                end
                // Down-sweep fills in the prefixes skipped by the up-sweep.
                for (int l = LV - 2; l >= 0; l--) begin
                    for (int i = 0; i < width; i++) begin
                        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l)))
                            t[i] = t[i] ^ t[i - (1 << l)];
                    end
                end
                po = t;
            end
        end else begin : g_serial
            always_comb begin
                t = pi;
                p = '0;
                for (int i = 1; i < width; i++)
                    t[i] = t[i] ^ t[i-1];
                po = t;
            end
        end
    endgenerate
endmodule

module prefix_xor_seq #(
    parameter int width  = 8,
    parameter int chunks = 4,
    parameter int speed  = 0
) (
    input logic             clk_i,
    input logic             rst_i,
    prefix_xor_seq_if.slave bus
);
    localparam int W  = width * chunks;
    localparam int KW = (chunks > 1) ? $clog2(chunks) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_n;
    logic [W-1:0]     opnd;
    logic [W-1:0]     res;
    logic [KW-1:0]    k;
    logic             carry;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             last;
    logic [width-1:0] chunk;
    logic [width-1:0] po;
    logic [width-1:0] cres;

    always_comb begin
        chunk = '0;
        for (int c = 0; c < chunks; c++) begin
            if (k == KW'(c))
                chunk = opnd[c*width +: width];
        end
    end

    prefix_xor #(
        .width (width),
        .speed (speed)
    ) u_px (
        .pi (chunk),
        .po (po)
    );

    assign cres = po ^ {width{carry}};
    assign last = (k == KW'(chunks - 1));

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i)
                    state_n = RUN;
            end
            RUN: begin
                if (last)
                    state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
`ifdef PREFIX_XOR_SEQ_OVERLAP_EN
                in_ready = bus.out_ready_i;
                if (bus.out_ready_i)
                    state_n = bus.in_valid_i ? RUN : IDLE;
`else
                if (bus.out_ready_i)
                    state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept = bus.in_valid_i & in_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            opnd  <= '0;
            res   <= '0;
            k     <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                opnd  <= bus.in_data_i;
                res   <= '0;
                k     <= '0;
                carry <= 1'b0;
            end else if (state == RUN) begin
                for (int c = 0; c < chunks; c++) begin
                    if (k == KW'(c))
                        res[c*width +: width] <= cres;
                end
                carry <= cres[width-1];
                if (!last)
                    k <= k + 1'b1;
            end
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = res;
    assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_prefix_xor_seq.sv
// Directed and random checks of prefix_xor_seq against a serial prefix-XOR model.
// Small 4x2 instance for handshake/reset behaviour; three 8x4 instances sweep speed.
module tb_prefix_xor_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0]  qa [$];
    logic [31:0] qw [$];

    logic        v32 = 1'b0;
    logic [31:0] d32 = '0;

    always #5 clk = ~clk;

    prefix_xor_seq_if #(.W(8))  ba ();
    prefix_xor_seq_if #(.W(32)) b0 ();
    prefix_xor_seq_if #(.W(32)) b1 ();
    prefix_xor_seq_if #(.W(32)) b2 ();

    assign b0.in_valid_i  = v32;
    assign b1.in_valid_i  = v32;
    assign b2.in_valid_i  = v32;
    assign b0.in_data_i   = d32;
    assign b1.in_data_i   = d32;
    assign b2.in_data_i   = d32;
    assign b0.out_ready_i = 1'b1;
    assign b1.out_ready_i = 1'b1;
    assign b2.out_ready_i = 1'b1;

    prefix_xor_seq #(.width(4), .chunks(2), .speed(0)) u_a (
        .clk_i (clk), .rst_i (rst), .bus (ba)
    );
    prefix_xor_seq #(.width(8), .chunks(4), .speed(0)) u_s0 (
        .clk_i (clk), .rst_i (rst), .bus (b0)
    );
    prefix_xor_seq #(.width(8), .chunks(4), .speed(1)) u_s1 (
        .clk_i (clk), .rst_i (rst), .bus (b1)
    );
    prefix_xor_seq #(.width(8), .chunks(4), .speed(2)) u_s2 (
        .clk_i (clk), .rst_i (rst), .bus (b2)
    );

    function automatic logic [31:0] px(input logic [31:0] x);
        logic [31:0] r;
        logic        a;
        a = 1'b0;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            a    = a ^ x[i];
            r[i] = a;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op_a(input logic [7:0] d, input bit hold);
        int          cyc;
        logic [31:0] m;
        logic [7:0]  e;
        logic [7:0]  snap;
        ba.out_ready_i = !hold;
        cyc = 0;
        while (ba.in_ready_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("a_in_ready", 64'(ba.in_ready_o), 64'(1));
        ba.in_valid_i = 1'b1;
        ba.in_data_i  = d;
        m = px({24'h0, d});
        qa.push_back(m[7:0]);
        @(negedge clk);
        ba.in_valid_i = 1'b0;
        cyc = 0;
        while (ba.out_valid_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("a_latency", 64'(cyc), 64'(2));
        if (hold) begin
            snap = ba.out_data_o;
            for (int j = 0; j < 5; j++) begin
                check("bp_valid", 64'(ba.out_valid_o), 64'(1));
                check("bp_data", 64'(ba.out_data_o), 64'(snap));
                check("bp_in_ready", 64'(ba.in_ready_o), 64'(0));
                @(negedge clk);
            end
            ba.out_ready_i = 1'b1;
        end
        check("a_sb_nonempty", 64'(qa.size()), 64'(1));
        e = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        check("a_result", 64'(ba.out_data_o), 64'(e));
        @(negedge clk);
        check("a_post_valid", 64'(ba.out_valid_o), 64'(0));
        check("a_post_in_ready", 64'(ba.in_ready_o), 64'(1));
        check("a_post_busy", 64'(ba.busy_o), 64'(0));
    endtask

    task automatic op_w(input logic [31:0] d);
        int          cyc;
        logic [31:0] e;
        cyc = 0;
        while (b0.in_ready_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w_in_ready", 64'(b0.in_ready_o), 64'(1));
        v32 = 1'b1;
        d32 = d;
        qw.push_back(px(d));
        @(negedge clk);
        v32 = 1'b0;
        cyc = 0;
        while (b0.out_valid_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("w_latency", 64'(cyc), 64'(4));
        e = (qw.size() > 0) ? qw.pop_front() : 32'hxxxxxxxx;
        check("w_speed0", 64'(b0.out_data_o), 64'(e));
        check("w_speed1", 64'(b1.out_data_o), 64'(e));
        check("w_speed2", 64'(b2.out_data_o), 64'(e));
        check("w_valid12", 64'({b1.out_valid_o, b2.out_valid_o}), 64'(3));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          saw;
        logic [31:0] m;
        logic [7:0]  e;
        logic [31:0] edge_ops [4];

        ba.in_valid_i  = 1'b0;
        ba.in_data_i   = '0;
        ba.out_ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ba.out_valid_o), 64'(0));
        check("rst_data", 64'(ba.out_data_o), 64'(0));
        check("rst_in_ready", 64'(ba.in_ready_o), 64'(1));
        check("rst_busy", 64'(ba.busy_o), 64'(0));
        check("rst_w_data", 64'(b0.out_data_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        op_a(8'h01, 1'b0);
        op_a(8'h11, 1'b0);
        op_a(8'h80, 1'b0);
        op_a(8'h00, 1'b0);
        op_a(8'hA5, 1'b1);

        ba.in_valid_i = 1'b1;
        ba.in_data_i  = 8'h11;
        @(negedge clk);
        ba.in_valid_i = 1'b0;
        check("mid_busy", 64'(ba.busy_o), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(ba.out_valid_o), 64'(0));
        check("mid_rst_data", 64'(ba.out_data_o), 64'(0));
        check("mid_rst_in_ready", 64'(ba.in_ready_o), 64'(1));
        check("mid_rst_busy", 64'(ba.busy_o), 64'(0));
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ba.out_valid_o !== 1'b0)
                saw = 1'b1;
        end
        check("no_stale", 64'(saw), 64'(0));
        op_a(8'h11, 1'b0);

`ifdef PREFIX_XOR_SEQ_OVERLAP_EN
        ba.out_ready_i = 1'b1;
        ba.in_valid_i  = 1'b1;
        ba.in_data_i   = 8'h01;
        m = px(32'h01);
        qa.push_back(m[7:0]);
        @(negedge clk);
        ba.in_valid_i = 1'b0;
        cyc = 0;
        while (ba.out_valid_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ov_first_seen", 64'(ba.out_valid_o), 64'(1));
        ba.in_valid_i = 1'b1;
        ba.in_data_i  = 8'h11;
        m = px(32'h11);
        qa.push_back(m[7:0]);
        check("ov_in_ready", 64'(ba.in_ready_o), 64'(1));
        e = qa.pop_front();
        check("ov_result0", 64'(ba.out_data_o), 64'(e));
        @(negedge clk);
        ba.in_valid_i = 1'b0;
        cyc = 1;
        while (ba.out_valid_o !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ov_gap", 64'(cyc), 64'(3));
        e = qa.pop_front();
        check("ov_result1", 64'(ba.out_data_o), 64'(e));
        @(negedge clk);
`endif

        edge_ops[0] = 32'h0000_0000;
        edge_ops[1] = 32'hFFFF_FFFF;
        edge_ops[2] = 32'h8000_0000;
        edge_ops[3] = 32'h0000_0001;
        for (int i = 0; i < 4; i++)
            op_w(edge_ops[i]);
        for (int i = 0; i < 300; i++)
            op_w($urandom);

        check("sb_a_empty", 64'(qa.size()), 64'(0));
        check("sb_w_empty", 64'(qw.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
